// File: rtl/dense_layer_engine.sv
// rtl/dense_layer_engine.sv - fully connected layer sequencer with signed fixed-point MAC datapath
module dense_layer_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 33,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       d_in,
  input  logic [15:0]       d_out,
  input  logic              relu,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_index,
  input  logic [DATA_W-1:0] w_data,
  output logic [15:0]       x_index,
  input  logic [DATA_W-1:0] x_data,
  output logic              y_write,
  output logic [15:0]       y_index,
  output logic [DATA_W-1:0] y_data
);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WRITE, DONE} state_t;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  state_t                    state;
  logic [15:0]               d_in_q, d_out_q, row, col;
  logic                      relu_q;
  logic [ADDR_W-1:0]         b_ptr, w_ptr;
  logic signed [ACC_W-1:0]   acc;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, acc_sum, shifted;
  logic [DATA_W-1:0]          y_next;

  assign prod     = $signed(w_data) * $signed(x_data);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC){w_data[DATA_W-1]}}, w_data, {FRAC{1'b0}}};
  assign acc_sum  = acc + prod_ext;

  // Output word is computed from the final sum so it can be registered on the DRAIN edge.
  always_comb begin
    shifted = acc_sum >>> FRAC;
    y_next  = shifted[DATA_W-1:0];
    if (shifted > MAX_V)
      y_next = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < MIN_V)
      y_next = {1'b1, {(DATA_W-1){1'b0}}};
    if (relu_q && y_next[DATA_W-1])
      y_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_write <= 1'b0;
      w_index <= '0;
      x_index <= '0;
      y_index <= '0;
      y_data  <= '0;
      acc     <= '0;
      row     <= '0;
      col     <= '0;
      b_ptr   <= '0;
      w_ptr   <= '0;
      d_in_q  <= '0;
      d_out_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      done    <= 1'b0;
      y_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (d_in != '0 && d_out != '0) begin
              state   <= BIAS;
              busy    <= 1'b1;
              d_in_q  <= d_in;
              d_out_q <= d_out;
              relu_q  <= relu;
              row     <= '0;
              w_index <= base_addr;
              b_ptr   <= base_addr + ADDR_W'(1);
              w_ptr   <= base_addr + ADDR_W'(d_out);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        BIAS: begin
          state   <= MAC;
          col     <= '0;
          w_index <= w_ptr;
          w_ptr   <= w_ptr + ADDR_W'(1);
          x_index <= '0;
        end
        MAC: begin
          // Column 0 sees the bias word on w_data; later columns see the previous weight.
          acc <= (col == '0) ? bias_ext : acc_sum;
          if (col == d_in_q - 16'd1) begin
            state <= DRAIN;
          end else begin
            col     <= col + 16'd1;
            w_index <= w_ptr;
            w_ptr   <= w_ptr + ADDR_W'(1);
            x_index <= col + 16'd1;
          end
        end
        DRAIN: begin
          acc     <= acc_sum;
          y_data  <= y_next;
          y_index <= row;
          y_write <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          if (row == d_out_q - 16'd1) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            row     <= row + 16'd1;
            w_index <= b_ptr;
            b_ptr   <= b_ptr + ADDR_W'(1);
            state   <= BIAS;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// tb/tb_dense_layer_engine.sv - directed self-checking bench for dense_layer_engine
module tb_dense_layer_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [32:0] base_addr;
  logic [15:0] d_in, d_out;
  logic        relu;
  logic        busy, done;
  logic [32:0] w_index;
  logic [15:0] w_data;
  logic [15:0] x_index;
  logic [15:0] x_data;
  logic        y_write;
  logic [15:0] y_index;
  logic [15:0] y_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] wmem [0:1023];
  logic [15:0] xmem [0:1023];

  logic [32:0] wi_log [0:255];
  logic [15:0] xi_log [0:255];
  logic        busy_log [0:255];
  logic [15:0] yi_log [0:63];
  logic [15:0] yd_log [0:63];
  int          done_at, n_writes, busy_seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_data <= wmem[w_index[9:0]];
    x_data <= xmem[x_index[9:0]];
  end

  dense_layer_engine dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .d_in(d_in), .d_out(d_out), .relu(relu), .busy(busy), .done(done),
    .w_index(w_index), .w_data(w_data), .x_index(x_index), .x_data(x_data),
    .y_write(y_write), .y_index(y_index), .y_data(y_data)
  );

  // Pulses start, then logs outputs per cycle (cycle 1 = cycle after start) until done or budget.
  task automatic run_layer(input logic [32:0] b, input int din, input int dout,
                           input logic rl, input int budget, input int poke);
    @(negedge clk);
    base_addr = b; d_in = 16'(din); d_out = 16'(dout); relu = rl; start = 1'b1;
    done_at = -1; n_writes = 0; busy_seen = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n < 256) begin
        wi_log[n] = w_index; xi_log[n] = x_index; busy_log[n] = busy;
      end
      if (busy) busy_seen = 1;
      if (y_write) begin
        if (n_writes < 64) begin
          yi_log[n_writes] = y_index; yd_log[n_writes] = y_data;
        end
        n_writes++;
      end
      if (done) begin
        done_at = n;
        break;
      end
      if (n == poke) begin
        base_addr = 33'd0; d_in = 16'd1; d_out = 16'd1; relu = 1'b1; start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic load_multi;
    wmem[100] = 16'd256;  wmem[101] = 16'hFE00; wmem[102] = 16'd0;
    wmem[103] = 16'd256;  wmem[104] = 16'd256;  wmem[105] = 16'd256;
    wmem[106] = 16'd512;  wmem[107] = 16'd0;    wmem[108] = 16'd0;
    wmem[109] = 16'd0;    wmem[110] = 16'hFF00; wmem[111] = 16'd0;
    xmem[0] = 16'd256; xmem[1] = 16'd512; xmem[2] = 16'hFF00;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; d_in = '0; d_out = '0; relu = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y_write !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b y_write=%b expected 0 0 0", busy, done, y_write);
    end
    checks++;
    if (w_index !== 33'd0 || x_index !== 16'd0 || y_index !== 16'd0 || y_data !== 16'd0) begin
      errors++; $display("FAIL reset_data: w_index=%0h x_index=%0h y_index=%0h y_data=%0h expected all 0",
                         w_index, x_index, y_index, y_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    wmem[0] = 16'd256; wmem[1] = 16'd512; wmem[2] = 16'd256;
    xmem[0] = 16'd256; xmem[1] = 16'd768;
    run_layer(33'd0, 2, 1, 1'b0, 50, -1);
    checks++;
    if (n_writes !== 1 || yi_log[0] !== 16'd0 || yd_log[0] !== 16'd1536) begin
      errors++; $display("FAIL basic_y: writes=%0d index=%0d data=%0d expected 1 0 1536", n_writes, yi_log[0], yd_log[0]);
    end
    checks++;
    if (done_at !== 6) begin
      errors++; $display("FAIL basic_latency: done at %0d expected 6", done_at);
    end
    checks++;
    if (wi_log[1] !== 33'd0 || wi_log[2] !== 33'd1 || wi_log[3] !== 33'd2 || xi_log[2] !== 16'd0 || xi_log[3] !== 16'd1) begin
      errors++; $display("FAIL basic_addr: w=%0d,%0d,%0d x=%0d,%0d expected 0,1,2 0,1",
                         wi_log[1], wi_log[2], wi_log[3], xi_log[2], xi_log[3]);
    end
  endtask

  task automatic test_relu;
    wmem[10] = 16'hFF00; wmem[11] = 16'd0; xmem[0] = 16'd300;
    run_layer(33'd10, 1, 1, 1'b0, 50, -1);
    checks++;
    if (yd_log[0] !== 16'hFF00 || done_at !== 5) begin
      errors++; $display("FAIL relu_off: data=%0h done=%0d expected ff00 5", yd_log[0], done_at);
    end
    run_layer(33'd10, 1, 1, 1'b1, 50, -1);
    checks++;
    if (yd_log[0] !== 16'h0000 || n_writes !== 1) begin
      errors++; $display("FAIL relu_on: data=%0h writes=%0d expected 0 1", yd_log[0], n_writes);
    end
  endtask

  task automatic test_saturation;
    wmem[20] = 16'h7FFF; wmem[21] = 16'h7FFF; xmem[0] = 16'h7FFF;
    run_layer(33'd20, 1, 1, 1'b0, 50, -1);
    checks++;
    if (yd_log[0] !== 16'h7FFF) begin
      errors++; $display("FAIL sat_pos: data=%0h expected 7fff", yd_log[0]);
    end
    wmem[20] = 16'h8000; xmem[0] = 16'h8000;
    run_layer(33'd20, 1, 1, 1'b0, 50, -1);
    checks++;
    if (yd_log[0] !== 16'h8000) begin
      errors++; $display("FAIL sat_neg: data=%0h expected 8000", yd_log[0]);
    end
  endtask

  task automatic test_truncation;
    wmem[30] = 16'd0; wmem[31] = 16'd1; xmem[0] = 16'hFFFF;
    run_layer(33'd30, 1, 1, 1'b0, 50, -1);
    checks++;
    if (yd_log[0] !== 16'hFFFF) begin
      errors++; $display("FAIL trunc_neg: data=%0h expected ffff", yd_log[0]);
    end
    xmem[0] = 16'd255;
    run_layer(33'd30, 1, 1, 1'b0, 50, -1);
    checks++;
    if (yd_log[0] !== 16'h0000) begin
      errors++; $display("FAIL trunc_pos: data=%0h expected 0", yd_log[0]);
    end
  endtask

  task automatic test_multi_row;
    int s;
    load_multi();
    run_layer(33'd100, 3, 3, 1'b0, 100, -1);
    checks++;
    if (n_writes !== 3 || done_at !== 19) begin
      errors++; $display("FAIL multi_count: writes=%0d done=%0d expected 3 19", n_writes, done_at);
    end
    checks++;
    if (yi_log[0] !== 16'd0 || yi_log[1] !== 16'd1 || yi_log[2] !== 16'd2) begin
      errors++; $display("FAIL multi_index: %0d %0d %0d expected 0 1 2", yi_log[0], yi_log[1], yi_log[2]);
    end
    checks++;
    if (yd_log[0] !== 16'd768 || yd_log[1] !== 16'd0 || yd_log[2] !== 16'hFE00) begin
      errors++; $display("FAIL multi_data: %0h %0h %0h expected 300 0 fe00", yd_log[0], yd_log[1], yd_log[2]);
    end
    for (int r = 0; r < 3; r++) begin
      s = 1 + r * 6;
      checks++;
      if (wi_log[s] !== 33'(100 + r)) begin
        errors++; $display("FAIL multi_bias_addr row %0d: got %0d expected %0d", r, wi_log[s], 100 + r);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (wi_log[s+1+c] !== 33'(103 + 3*r + c) || xi_log[s+1+c] !== 16'(c)) begin
          errors++; $display("FAIL multi_mac_addr r%0d c%0d: w=%0d x=%0d expected %0d %0d",
                             r, c, wi_log[s+1+c], xi_log[s+1+c], 103 + 3*r + c, c);
        end
      end
      checks++;
      if (wi_log[s+4] !== 33'(105 + 3*r) || wi_log[s+5] !== 33'(105 + 3*r) || xi_log[s+5] !== 16'd2) begin
        errors++; $display("FAIL multi_hold r%0d: w=%0d,%0d x=%0d expected %0d 2",
                           r, wi_log[s+4], wi_log[s+5], xi_log[s+5], 105 + 3*r);
      end
    end
    checks++;
    for (int n = 1; n < 19; n++)
      if (busy_log[n] !== 1'b1) s = -n;
    if (s < 0 || busy_log[19] !== 1'b0) begin
      errors++; $display("FAIL multi_busy: low at cycle %0d or busy at done=%b expected high until done", -s, busy_log[19]);
    end
  endtask

  task automatic test_wrap;
    wmem[1023] = 16'd256; wmem[0] = 16'd512; xmem[0] = 16'd256;
    run_layer(33'h1_FFFF_FFFF, 1, 1, 1'b0, 50, -1);
    checks++;
    if (wi_log[1] !== 33'h1_FFFF_FFFF || wi_log[2] !== 33'd0 || yd_log[0] !== 16'd768) begin
      errors++; $display("FAIL addr_wrap: w=%0h,%0h data=%0d expected 1ffffffff,0 768", wi_log[1], wi_log[2], yd_log[0]);
    end
  endtask

  task automatic test_busy_start;
    load_multi();
    run_layer(33'd100, 3, 3, 1'b0, 100, 4);
    checks++;
    if (done_at !== 19 || n_writes !== 3) begin
      errors++; $display("FAIL busy_start_count: done=%0d writes=%0d expected 19 3", done_at, n_writes);
    end
    checks++;
    if (yd_log[0] !== 16'd768 || yd_log[1] !== 16'd0 || yd_log[2] !== 16'hFE00) begin
      errors++; $display("FAIL busy_start_data: %0h %0h %0h expected 300 0 fe00", yd_log[0], yd_log[1], yd_log[2]);
    end
  endtask

  task automatic test_reset_mid;
    int wr, post;
    load_multi();
    @(negedge clk);
    base_addr = 33'd100; d_in = 16'd3; d_out = 16'd8; relu = 1'b0; start = 1'b1;
    wr = 0; post = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (y_write) wr++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wr !== 5) begin
      errors++; $display("FAIL rst_mid_pre_writes: got %0d expected 5", wr);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y_write !== 1'b0 || w_index !== 33'd0 ||
        x_index !== 16'd0 || y_index !== 16'd0 || y_data !== 16'd0) begin
      errors++; $display("FAIL rst_mid_outputs: busy=%b done=%b yw=%b wi=%0h xi=%0h yi=%0h yd=%0h expected all 0",
                         busy, done, y_write, w_index, x_index, y_index, y_data);
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (y_write || done || busy) post++;
    end
    checks++;
    if (post !== 0) begin
      errors++; $display("FAIL rst_mid_quiet: %0d active cycles after reset expected 0", post);
    end
    run_layer(33'd100, 3, 3, 1'b0, 100, -1);
    checks++;
    if (done_at !== 19 || n_writes !== 3 || yd_log[0] !== 16'd768 || yd_log[2] !== 16'hFE00) begin
      errors++; $display("FAIL rst_mid_restart: done=%0d writes=%0d d0=%0h d2=%0h expected 19 3 300 fe00",
                         done_at, n_writes, yd_log[0], yd_log[2]);
    end
  endtask

  task automatic test_zero;
    run_layer(33'd0, 0, 3, 1'b0, 20, -1);
    checks++;
    if (done_at !== 1 || busy_seen !== 0 || n_writes !== 0) begin
      errors++; $display("FAIL zero_din: done=%0d busy_seen=%0d writes=%0d expected 1 0 0", done_at, busy_seen, n_writes);
    end
    run_layer(33'd0, 3, 0, 1'b0, 20, -1);
    checks++;
    if (done_at !== 1 || busy_seen !== 0 || n_writes !== 0) begin
      errors++; $display("FAIL zero_dout: done=%0d busy_seen=%0d writes=%0d expected 1 0 0", done_at, busy_seen, n_writes);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 16'd0; xmem[i] = 16'd0;
    end
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_truncation();
    test_multi_row();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
